// File: rtl/gin_pkg.sv
// Shared types and helpers for the filter GIN dispatcher: FSM state encoding,
// default array geometry and the flat PE index mapping.
package gin_pkg;

   localparam int DEFAULT_NUM_ROWS      = 12;
   localparam int DEFAULT_NUM_COLS      = 14;
   localparam int DEFAULT_DATA_WIDTH    = 64;
   localparam int DEFAULT_ROW_TAG_WIDTH = 4;
   localparam int DEFAULT_COL_TAG_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      POP   = 2'd1,
      LATCH = 2'd2,
      SEND  = 2'd3
   } state_t;

   // Flat bit position of PE (row, col) in pe_valid / pe_ready.
   function automatic int pe_index(input int row, input int col, input int num_cols);
      return row * num_cols + col;
   endfunction

endpackage

// File: rtl/filter_gin_dispatcher_if.sv
// GIN/tag FIFO read side plus PE array filter ports of the dispatcher.
// master = dispatcher, slave = FIFO/PE array environment.
interface filter_gin_dispatcher_if
   import gin_pkg::*;
#(
   parameter int NUM_ROWS      = DEFAULT_NUM_ROWS,
   parameter int NUM_COLS      = DEFAULT_NUM_COLS,
   parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
   parameter int ROW_TAG_WIDTH = DEFAULT_ROW_TAG_WIDTH,
   parameter int COL_TAG_WIDTH = DEFAULT_COL_TAG_WIDTH
);
   localparam int NUM_PE = NUM_ROWS * NUM_COLS;

   logic                     gin_empty;
   logic                     re_to_gin_fifo;
   logic [DATA_WIDTH-1:0]    gin_data;
   logic                     tags_empty;
   logic [ROW_TAG_WIDTH-1:0] row_tag;
   logic [COL_TAG_WIDTH-1:0] col_tag;
   logic [NUM_PE-1:0]        pe_valid;
   logic [NUM_PE-1:0]        pe_ready;
   logic [DATA_WIDTH-1:0]    pe_data;

   modport master (
      input  gin_empty, gin_data, tags_empty, row_tag, col_tag, pe_ready,
      output re_to_gin_fifo, pe_valid, pe_data
   );

   modport slave (
      output gin_empty, gin_data, tags_empty, row_tag, col_tag, pe_ready,
      input  re_to_gin_fifo, pe_valid, pe_data
   );

endinterface

// File: rtl/gin_tag_matcher.sv
// Row/column ID register file (all-ones after reset) and combinational target
// mask: a PE matches when its row ID equals row_tag and its col ID equals col_tag.
module gin_tag_matcher
   import gin_pkg::*;
#(
   parameter int NUM_ROWS      = DEFAULT_NUM_ROWS,
   parameter int NUM_COLS      = DEFAULT_NUM_COLS,
   parameter int ROW_TAG_WIDTH = DEFAULT_ROW_TAG_WIDTH,
   parameter int COL_TAG_WIDTH = DEFAULT_COL_TAG_WIDTH,
   parameter int ROW_SEL_W     = $clog2(NUM_ROWS),
   parameter int COL_SEL_W     = $clog2(NUM_COLS)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          id_we,
   input  logic [ROW_SEL_W-1:0]          id_row,
   input  logic [COL_SEL_W-1:0]          id_col,
   input  logic [ROW_TAG_WIDTH-1:0]      id_row_val,
   input  logic [COL_TAG_WIDTH-1:0]      id_col_val,
   input  logic [ROW_TAG_WIDTH-1:0]      row_tag,
   input  logic [COL_TAG_WIDTH-1:0]      col_tag,
   output logic [NUM_ROWS*NUM_COLS-1:0]  mask
);

   genvar gi, gj;
   generate
      for (gi = 0; gi < NUM_ROWS; gi++) begin : g_row
         localparam logic [ROW_SEL_W-1:0] ROW_SEL = ROW_SEL_W'(gi);
         logic [ROW_TAG_WIDTH-1:0] row_id_reg;
         logic                     row_hit;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset)
               row_id_reg <= '1;
            else if (id_we && id_row == ROW_SEL)
               row_id_reg <= id_row_val;
         end

         assign row_hit = (row_id_reg == row_tag);

         for (gj = 0; gj < NUM_COLS; gj++) begin : g_col
            localparam logic [COL_SEL_W-1:0] COL_SEL = COL_SEL_W'(gj);
            localparam int PE_IDX = pe_index(gi, gj, NUM_COLS);
            logic [COL_TAG_WIDTH-1:0] col_id_reg;

            always_ff @(posedge clk or negedge reset) begin
               if (!reset)
                  col_id_reg <= '1;
               else if (id_we && id_row == ROW_SEL && id_col == COL_SEL)
                  col_id_reg <= id_col_val;
            end

            assign mask[PE_IDX] = row_hit && (col_id_reg == col_tag);
         end
      end
   endgenerate

endmodule

// File: rtl/filter_gin_dispatcher.sv
// Pops GIN data + tag pairs and multicasts each word to all matching PEs.
// Optional macro FILTER_GIN_DROP_CNT_EN adds a saturating drop_cnt output.
module filter_gin_dispatcher
   import gin_pkg::*;
#(
   parameter int NUM_ROWS      = DEFAULT_NUM_ROWS,
   parameter int NUM_COLS      = DEFAULT_NUM_COLS,
   parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
   parameter int ROW_TAG_WIDTH = DEFAULT_ROW_TAG_WIDTH,
   parameter int COL_TAG_WIDTH = DEFAULT_COL_TAG_WIDTH,
   parameter int ROW_SEL_W     = $clog2(NUM_ROWS),
   parameter int COL_SEL_W     = $clog2(NUM_COLS)
) (
   input  logic                     clk,
   input  logic                     reset,
   filter_gin_dispatcher_if.master  bus,
   input  logic                     id_we,
   input  logic [ROW_SEL_W-1:0]     id_row,
   input  logic [COL_SEL_W-1:0]     id_col,
   input  logic [ROW_TAG_WIDTH-1:0] id_row_val,
   input  logic [COL_TAG_WIDTH-1:0] id_col_val,
   output logic                     busy
`ifdef FILTER_GIN_DROP_CNT_EN
  ,output logic [15:0]              drop_cnt
`endif
);

   localparam int NUM_PE = NUM_ROWS * NUM_COLS;

   state_t                state_reg;
   logic                  re_reg;
   logic [DATA_WIDTH-1:0] data_reg;
   logic [NUM_PE-1:0]     pending_reg;
   logic [NUM_PE-1:0]     pending_next;
   logic [NUM_PE-1:0]     mask;
   logic                  fifos_ready;

   gin_tag_matcher #(
      .NUM_ROWS      (NUM_ROWS),
      .NUM_COLS      (NUM_COLS),
      .ROW_TAG_WIDTH (ROW_TAG_WIDTH),
      .COL_TAG_WIDTH (COL_TAG_WIDTH),
      .ROW_SEL_W     (ROW_SEL_W),
      .COL_SEL_W     (COL_SEL_W)
   ) u_matcher (
      .clk        (clk),
      .reset      (reset),
      .id_we      (id_we),
      .id_row     (id_row),
      .id_col     (id_col),
      .id_row_val (id_row_val),
      .id_col_val (id_col_val),
      .row_tag    (bus.row_tag),
      .col_tag    (bus.col_tag),
      .mask       (mask)
   );

   assign fifos_ready = !bus.gin_empty && !bus.tags_empty;

   // Ready from untargeted PEs falls out naturally: their pending bit is already 0.
   always_comb begin
      pending_next = pending_reg & ~bus.pe_ready;
   end

`ifdef FILTER_GIN_DROP_CNT_EN
   logic [15:0] drop_cnt_reg;
   assign drop_cnt = drop_cnt_reg;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         re_reg      <= 1'b0;
         data_reg    <= '0;
         pending_reg <= '0;
`ifdef FILTER_GIN_DROP_CNT_EN
         drop_cnt_reg <= '0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (fifos_ready) begin
                  state_reg <= POP;
                  re_reg    <= 1'b1;
               end
            end
            POP: begin
               re_reg    <= 1'b0;
               state_reg <= LATCH;
            end
            LATCH: begin
               data_reg    <= bus.gin_data;
               pending_reg <= mask;
               if (mask == '0) begin
                  state_reg <= IDLE;
`ifdef FILTER_GIN_DROP_CNT_EN
                  if (drop_cnt_reg != 16'hFFFF)
                     drop_cnt_reg <= drop_cnt_reg + 16'd1;
`endif
               end else begin
                  state_reg <= SEND;
               end
            end
            SEND: begin
               pending_reg <= pending_next;
               if (pending_next == '0) begin
                  // Back-to-back: skip IDLE when the next entry is already waiting.
                  if (fifos_ready) begin
                     state_reg <= POP;
                     re_reg    <= 1'b1;
                  end else begin
                     state_reg <= IDLE;
                  end
               end
            end
            default: begin
               state_reg <= IDLE;
               re_reg    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.re_to_gin_fifo = re_reg;
   assign bus.pe_valid       = pending_reg;
   assign bus.pe_data        = data_reg;
   assign busy               = (state_reg != IDLE);

endmodule

// File: doc/filter_gin_dispatcher.md
Name: filter_gin_dispatcher

Overview:
Downstream consumer of the filter NoC controller's GIN data FIFO and tag FIFO. Pops one packed filter word plus its (row_tag, col_tag) pair and builds a target mask over the PE array by comparing tags with per-row and per-PE ID registers. Multicasts the word to every matching PE and holds each target until it accepts, then moves to the next entry. Sits between the filter GIN/tag FIFOs and the PE array filter input ports.

Parameters:
NUM_ROWS, 12, PE array rows
NUM_COLS, 14, PEs per row
DATA_WIDTH, 64, packed filter word width (matches GIN FIFO read width)
ROW_TAG_WIDTH, 4, row tag / row ID width
COL_TAG_WIDTH, 4, column tag / column ID width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
gin_empty  in  1  GIN data FIFO empty
re_to_gin_fifo  out  1  pop request; also pops the tag FIFO; read data valid one cycle later
gin_data  in  DATA_WIDTH  GIN FIFO read data
tags_empty  in  1  tag FIFO empty
row_tag  in  ROW_TAG_WIDTH  tag FIFO row tag
col_tag  in  COL_TAG_WIDTH  tag FIFO column tag
id_we  in  1  ID configuration write strobe
id_row  in  $clog2(NUM_ROWS)  row written by id_we
id_col  in  $clog2(NUM_COLS)  PE written by id_we (col ID)
id_row_val  in  ROW_TAG_WIDTH  row ID value (written with id_we)
id_col_val  in  COL_TAG_WIDTH  column ID value (written with id_we)
pe_valid  out  NUM_ROWS*NUM_COLS  per-PE data valid, bit index row*NUM_COLS+col
pe_ready  in  NUM_ROWS*NUM_COLS  per-PE accept
pe_data  out  DATA_WIDTH  broadcast word, shared by all PEs
busy  out  1  high while not in IDLE

Behaviour:
- Reset: pe_valid=0, pe_data=0, re_to_gin_fifo=0, busy=0, state=IDLE, all ID registers=all-ones (match nothing until configured, unless tag is all-ones).
- ID writes: on id_we, row_id[id_row] <= id_row_val and col_id[id_row][id_col] <= id_col_val. Writes are accepted in any state. A change takes effect at the next LATCH.
- FSM states IDLE, POP, LATCH, SEND.
- IDLE: if ~gin_empty & ~tags_empty, go to POP. An empty mismatch between the two FIFOs means wait; it is not an error.
- POP: re_to_gin_fifo=1 for exactly this cycle, then go to LATCH.
- LATCH: register gin_data into pe_data. Build pending mask bit[i] = (row_id[r]==row_tag) & (col_id[r][c]==col_tag). Mask zero means the word is dropped and the FSM returns to IDLE. Otherwise go to SEND.
- SEND: pe_valid = pending. Each cycle, clear pending bits where pe_valid & pe_ready. When the next pending value is zero, go to POP if both FIFOs are non-empty (back-to-back), else IDLE.
- Throughput: 3 cycles per word when all targets accept immediately.
- pe_data is stable throughout SEND. pe_valid never deasserts for a PE before its handshake.
- A PE asserting ready while not targeted has no effect.
- Reset mid-SEND: pending is cleared immediately and the word is lost. No partial state survives.

Optional Feature:
FILTER_GIN_DROP_CNT_EN
- Defined: adds output drop_cnt [15:0], reset 0. It increments on each LATCH with a zero mask and saturates at 16'hFFFF.
- Undefined: port and counter absent; drops are silent.

Decomposition:
- Package gin_pkg: state enum (IDLE, POP, LATCH, SEND), PE index helper function, default array dimensions.
- Sub-module gin_tag_matcher: ID register file plus combinational mask generation (row/col compare). The FSM, pending register and FIFO handshake stay in filter_gin_dispatcher.

Test Plan:
- Config all rows ID 0..11, all col IDs 0; push word 64'hA5A5_0001_0002_0003 with tag (3,0) -> only row 3's 14 PEs see valid; pe_data matches; done in 3 cycles with all ready high.
- Tag (5,2) with row 5, PE 7 col ID 2 -> single-bit pe_valid at index 77; hold ready low 10 cycles -> valid and data held, no further pop.
- Target 14 PEs, ready staggered one PE per cycle -> pending bits clear individually; next pop only after the last accept.
- Tag (15,15) with no matching IDs -> no pe_valid; FSM back in IDLE after LATCH; with FILTER_GIN_DROP_CNT_EN, drop_cnt=1.
- Tag FIFO empty, GIN non-empty -> no re_to_gin_fifo until tags arrive; then a single pop.
- Assert reset mid-SEND -> pe_valid=0, busy=0 immediately (asynchronous); the next entry dispatches normally after release.
